mixer_pwm: RTL and testbench

MIXER_PWM -- requirements
Module: mixer_pwm

---
 rtl/synth_pkg.sv | 13 +
 rtl/mixer_pwm_if.sv | 31 +++
 rtl/pwm_dac.sv | 72 +++++++
 rtl/mixer_pwm.sv | 68 ++++++
 tb/tb_mixer_pwm.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared synthesiser constants used by the channels, the mixer and the PWM DAC.
//   NUM_CH     : number of channels mixed
//   SAMPLE_W   : width of a channel sample, of the mix and of the PWM counter
//   VOL_W      : per-channel volume width
//   MIX_SHIFT  : right shift that scales the product sum back into SAMPLE_W
//   PWM_PERIOD : PWM period in clock cycles (2**SAMPLE_W)
package synth_pkg;
    localparam int NUM_CH     = 4;
    localparam int SAMPLE_W   = 11;
    localparam int VOL_W      = 4;
    localparam int MIX_SHIFT  = 6;
    localparam int PWM_PERIOD = 2048;
endpackage

// File: rtl/mixer_pwm_if.sv
// Signal bundle between the mixer_pwm block and whoever drives it.
//   master : drives ena, ch_in, vol, mute; observes mix, pwm_out, period_start
//            and the debug view of the PWM counter and duty register
//   slave  : the mixer_pwm block itself
// Handshake: there is none. Every input is sampled on every rising clk edge
// (no valid/ready), and every output is a register that is valid each cycle.
interface mixer_pwm_if #(
    parameter int NUM_CH   = synth_pkg::NUM_CH,
    parameter int SAMPLE_W = synth_pkg::SAMPLE_W,
    parameter int VOL_W    = synth_pkg::VOL_W
);
    logic                               ena;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]    ch_in;
    logic [NUM_CH-1:0][VOL_W-1:0]       vol;
    logic [NUM_CH-1:0]                  mute;
    logic [SAMPLE_W-1:0]                mix;
    logic                               period_start;
    logic                               pwm_out;
    logic [SAMPLE_W-1:0]                dbg_cnt;
    logic [SAMPLE_W-1:0]                dbg_duty;

    modport master (
        output ena, ch_in, vol, mute,
        input  mix, period_start, pwm_out, dbg_cnt, dbg_duty
    );

    modport slave (
        input  ena, ch_in, vol, mute,
        output mix, period_start, pwm_out, dbg_cnt, dbg_duty
    );
endinterface

// File: rtl/pwm_dac.sv
// PWM DAC: free-running period counter, duty register and compare.
//   clk, rst     : clock, synchronous active-high reset
//   ena          : run enable; low holds cnt at 0 and the output low
//   duty_in      : duty value, captured only at a period boundary
//   pwm_out      : registered PWM output, high while cnt < duty
//   period_start : one-cycle pulse on the first cycle (cnt = 0) of a period
//   dbg_cnt      : current counter value
//   dbg_duty     : current duty register value
module pwm_dac import synth_pkg::*; #(
    parameter int CNT_W = synth_pkg::SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [CNT_W-1:0] duty_in,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] dbg_cnt,
    output logic [CNT_W-1:0] dbg_duty
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q,  pwm_d;
    logic             ps_q,   ps_d;
    // running_q is low after reset or while disabled, so the next enabled
    // edge opens a fresh period instead of continuing an old one.
    logic             running_q, running_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            ps_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            ps_q      <= ps_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        ps_d      = 1'b0;
        running_d = running_q;
        if (!ena) begin
            cnt_d     = '0;
            running_d = 1'b0;
        end else if (!running_q || cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            duty_d    = duty_in;
            ps_d      = 1'b1;
            running_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Compare uses next-cycle count and duty so the registered output
        // lines up with the counter value it is shown alongside.
        pwm_d = ena && (cnt_d < duty_d);
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign dbg_cnt      = cnt_q;
    assign dbg_duty     = duty_q;
endmodule

// File: rtl/mixer_pwm.sv
// Channel mixer with PWM audio output.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mixer_pwm_if slave port
//              ena, ch_in, vol, mute in; mix, period_start, pwm_out,
//              dbg_cnt, dbg_duty out
// Stage 1 registers each channel's volume-scaled (or muted) product, stage 2
// registers the scaled sum, so mix follows the inputs by exactly two cycles
// regardless of ena. The mix feeds the PWM DAC duty input.
module mixer_pwm import synth_pkg::*; #(
    parameter int NUM_CH   = synth_pkg::NUM_CH,
    parameter int SAMPLE_W = synth_pkg::SAMPLE_W,
    parameter int VOL_W    = synth_pkg::VOL_W
) (
    input  logic        clk,
    input  logic        rst,
    mixer_pwm_if.slave  bus
);
    localparam int PROD_W = SAMPLE_W + VOL_W;
    // Wide enough to add NUM_CH full-scale products without overflow.
    localparam int SUM_W  = PROD_W + $clog2(NUM_CH);

    logic [NUM_CH-1:0][PROD_W-1:0] prod_q;
    logic [SUM_W-1:0]              sum;
    logic [SAMPLE_W-1:0]           mix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                prod_q[i] <= bus.mute[i] ? '0
                           : PROD_W'(bus.ch_in[i]) * PROD_W'(bus.vol[i]);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SUM_W'(prod_q[i]);
        end
    end

    // Full scale (4 x 2047 x 15) >> 6 = 1919 fits in SAMPLE_W, so the
    // truncation after the shift never drops a set bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_q <= '0;
        end else begin
            mix_q <= SAMPLE_W'(sum >> MIX_SHIFT);
        end
    end

    assign bus.mix = mix_q;

    pwm_dac #(
        .CNT_W (SAMPLE_W)
    ) u_pwm_dac (
        .clk          (clk),
        .rst          (rst),
        .ena          (bus.ena),
        .duty_in      (mix_q),
        .pwm_out      (bus.pwm_out),
        .period_start (bus.period_start),
        .dbg_cnt      (bus.dbg_cnt),
        .dbg_duty     (bus.dbg_duty)
    );
endmodule

// File: tb/tb_mixer_pwm.sv
// Self-checking bench for mixer_pwm: mix values are predicted from the
// stimulus and queued; PWM periods are measured cycle by cycle.
module tb_mixer_pwm;
    import synth_pkg::*;

    typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] ch_t;
    typedef logic [NUM_CH-1:0][VOL_W-1:0]    vol_t;
    typedef logic [NUM_CH-1:0]               mute_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [SAMPLE_W-1:0] exp_q[$];

    ch_t   ch_full, ch_128;
    vol_t  vol_full;

    mixer_pwm_if bus ();

    mixer_pwm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [SAMPLE_W-1:0] model_mix(ch_t ch, vol_t v, mute_t m);
        int s;
        s = 0;
        for (int i = 0; i < NUM_CH; i++)
            if (!m[i]) s += int'(ch[i]) * int'(v[i]);
        return SAMPLE_W'(s / 64);
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input ch_t ch, input vol_t v, input mute_t m);
        bus.ch_in = ch;
        bus.vol   = v;
        bus.mute  = m;
        exp_q.push_back(model_mix(ch, v, m));
    endtask

    task automatic check_mix(input string name);
        logic [SAMPLE_W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected mix queued, mix=%0d", name, bus.mix);
        end else begin
            e = exp_q.pop_front();
            if (bus.mix !== e) begin
                failures++;
                $display("FAIL %s: mix=%0d expected %0d", name, bus.mix, e);
            end
        end
    endtask

    task automatic apply_and_check(input ch_t ch, input vol_t v, input mute_t m,
                                   input string name);
        @(negedge clk);
        drive(ch, v, m);
        repeat (2) @(negedge clk);
        check_mix(name);
    endtask

    task automatic wait_ps(input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            found = (bus.period_start === 1'b1);
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: no period_start within 3000 cycles", name);
        end
    endtask

    task automatic wait_cnt(input int target, input string name);
        bit found;
        found = (bus.dbg_cnt === SAMPLE_W'(target));
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            found = (bus.dbg_cnt === SAMPLE_W'(target));
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: cnt never reached %0d", name, target);
        end
    endtask

    // Starts on a negedge showing period_start, ends on the next one.
    task automatic check_period(input int exp_high, input string name);
        int highs, len;
        highs = 0;
        len   = 0;
        do begin
            if (bus.pwm_out === 1'b1) highs++;
            len++;
            @(negedge clk);
        end while (bus.period_start !== 1'b1 && len < 3000);
        checks++;
        if (len != 2048) begin
            failures++;
            $display("FAIL %s_len: period=%0d expected 2048", name, len);
        end
        checks++;
        if (highs != exp_high) begin
            failures++;
            $display("FAIL %s_high: high cycles=%0d expected %0d", name, highs, exp_high);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ena = 1'b1;
        bus.ch_in = ch_full;
        bus.vol = vol_full;
        bus.mute = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rst_mix",  int'(bus.mix), 0);
            check_val("rst_pwm",  int'(bus.pwm_out), 0);
            check_val("rst_ps",   int'(bus.period_start), 0);
            check_val("rst_cnt",  int'(bus.dbg_cnt), 0);
            check_val("rst_duty", int'(bus.dbg_duty), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("rel_ps",   int'(bus.period_start), 1);
        check_val("rel_cnt",  int'(bus.dbg_cnt), 0);
        check_val("rel_duty", int'(bus.dbg_duty), 0);
        @(negedge clk);
        check_val("rel_ps2",  int'(bus.period_start), 0);
        check_val("rel_cnt2", int'(bus.dbg_cnt), 1);
    endtask

    task automatic test_full_scale();
        apply_and_check(ch_full, vol_full, '0, "full_mix");
        wait_ps("full_ps");
        check_val("full_duty", int'(bus.dbg_duty), 1919);
        check_val("full_cnt0", int'(bus.dbg_cnt), 0);
        check_period(1919, "full_period");
    endtask

    task automatic test_single_mute();
        ch_t ch;
        vol_t v;
        for (int i = 0; i < NUM_CH; i++) begin
            ch[i] = SAMPLE_W'($urandom_range(0, 2047));
            v[i]  = VOL_W'($urandom_range(0, 15));
        end
        ch[0] = 11'd1024;
        v[0]  = 4'd8;
        apply_and_check(ch, v, mute_t'(4'b1110), "single_mix");
        @(negedge clk);
        drive(ch, v, mute_t'(4'b1111));
        @(negedge clk);
        check_val("mute_latency_hold", int'(bus.mix), 128);
        @(negedge clk);
        check_mix("mute_mix");
        wait_ps("mute_ps");
        check_val("mute_duty", int'(bus.dbg_duty), 0);
        check_period(0, "mute_period");
    endtask

    task automatic test_vol_zero();
        ch_t ch;
        mute_t m;
        for (int i = 0; i < NUM_CH; i++) ch[i] = SAMPLE_W'($urandom_range(0, 2047));
        m = mute_t'($urandom_range(0, 15));
        apply_and_check(ch, '0, m, "vol0_mix");
        wait_ps("vol0_ps");
        check_period(0, "vol0_period_a");
        check_period(0, "vol0_period_b");
    endtask

    task automatic test_midperiod_change();
        int highs, len, at;
        bit drove;
        apply_and_check(ch_full, vol_full, '0, "mid_mix_full");
        wait_ps("mid_ps");
        check_val("mid_duty", int'(bus.dbg_duty), 1919);
        highs = 0;
        len   = 0;
        at    = 0;
        drove = 1'b0;
        do begin
            if (drove && len == at + 2) check_mix("mid_mix_128");
            if (!drove && bus.dbg_cnt === 11'd1000) begin
                drive(ch_128, vol_full, '0);
                drove = 1'b1;
                at = len;
            end
            if (bus.pwm_out === 1'b1) highs++;
            len++;
            @(negedge clk);
        end while (bus.period_start !== 1'b1 && len < 3000);
        check_val("mid_len", len, 2048);
        check_val("mid_high_cur", highs, 1919);
        check_val("mid_duty_next", int'(bus.dbg_duty), 128);
        check_period(128, "mid_period_next");
    endtask

    task automatic test_reset_midperiod();
        wait_cnt(500, "rstmid_cnt500");
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rstmid_mix",  int'(bus.mix), 0);
            check_val("rstmid_pwm",  int'(bus.pwm_out), 0);
            check_val("rstmid_ps",   int'(bus.period_start), 0);
            check_val("rstmid_cnt",  int'(bus.dbg_cnt), 0);
            check_val("rstmid_duty", int'(bus.dbg_duty), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("rstmid_rel_ps",  int'(bus.period_start), 1);
        check_val("rstmid_rel_cnt", int'(bus.dbg_cnt), 0);
    endtask

    task automatic test_ena_drop();
        apply_and_check(ch_full, vol_full, '0, "ena_mix_full");
        wait_ps("ena_ps");
        check_val("ena_duty_pre", int'(bus.dbg_duty), 1919);
        wait_cnt(300, "ena_cnt300");
        bus.ena = 1'b0;
        drive(ch_128, vol_full, '0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 1) check_mix("ena_off_mix");
            check_val("ena_off_pwm",  int'(bus.pwm_out), 0);
            check_val("ena_off_ps",   int'(bus.period_start), 0);
            check_val("ena_off_cnt",  int'(bus.dbg_cnt), 0);
            check_val("ena_off_duty", int'(bus.dbg_duty), 1919);
        end
        bus.ena = 1'b1;
        @(negedge clk);
        check_val("ena_on_ps",   int'(bus.period_start), 1);
        check_val("ena_on_cnt",  int'(bus.dbg_cnt), 0);
        check_val("ena_on_duty", int'(bus.dbg_duty), 128);
        check_period(128, "ena_on_period");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_full[i]  = 11'd2047;
            vol_full[i] = 4'd15;
            ch_128[i]   = '0;
        end
        ch_128[0] = 11'd547;   // 547 * 15 / 64 = 128
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.ch_in = '0;
        bus.vol = '0;
        bus.mute = '0;

        test_reset();
        test_full_scale();
        test_single_mute();
        test_vol_zero();
        test_midperiod_change();
        test_reset_midperiod();
        test_ena_drop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
